// File: rtl/risc_pkg.sv
// Shared constants, opcode classes and register reset values for the 8-bit RISC core.
package risc_pkg;

    localparam int DATA_W = 8;
    localparam int REG_N  = 4;
    localparam int IDX_W  = 2;
    localparam int CNT_W  = 16;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Element [i] is the reset value of register Ri.
    localparam logic [REG_N-1:0][DATA_W-1:0] REG_RESET_VALS = {8'd20, 8'd15, 8'd10, 8'd5};

    function automatic logic is_writing(input logic [3:0] opcode);
        return (opcode != OP_NOP) && (opcode != OP_HALT);
    endfunction

endpackage

// File: rtl/risc_regfile.sv
// Architectural register file: one synchronous write port and two combinational read ports.
module risc_regfile
    import risc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr_a,
    input  logic [IDX_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [REG_N];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= REG_RESET_VALS[i];
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/risc_writeback_stage.sv
// EX/WB pipeline register, commit to the register file, flags, sticky halt and retire counter.
// Optional WB-to-read bypass is enabled by defining RISC_WB_FORWARD_EN.
module risc_writeback_stage
    import risc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [3:0]        ex_opcode,
    input  logic [IDX_W-1:0]  ex_dest,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_carry,
    input  logic [IDX_W-1:0]  rd_addr_a,
    input  logic [IDX_W-1:0]  rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              wb_valid,
    output logic [IDX_W-1:0]  wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_count
);

    // Handshake: ex_valid alone qualifies a transfer; there is no ready, the stage accepts
    // one instruction every cycle unless halted.
    logic [3:0]        wb_opcode;
    logic              wb_carry;
    logic              commit_write;
    logic              commit_halt;
    logic              capture;
    logic [DATA_W-1:0] rf_data_a;
    logic [DATA_W-1:0] rf_data_b;

    assign commit_write = wb_valid && is_writing(wb_opcode);
    assign commit_halt  = wb_valid && (wb_opcode == OP_HALT);
    // Anything arriving while HALT commits is younger than HALT, so it is dropped too.
    assign capture      = ex_valid && !halted && !commit_halt;

    risc_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (commit_write),
        .waddr   (wb_dest),
        .wdata   (wb_data),
        .raddr_a (rd_addr_a),
        .raddr_b (rd_addr_b),
        .rdata_a (rf_data_a),
        .rdata_b (rf_data_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid      <= 1'b0;
            wb_opcode     <= OP_NOP;
            wb_dest       <= '0;
            wb_data       <= '0;
            wb_carry      <= 1'b0;
            flag_zero     <= 1'b0;
            flag_carry    <= 1'b0;
            halted        <= 1'b0;
            retired_count <= '0;
        end else begin
            wb_valid <= capture;
            if (capture) begin
                wb_opcode <= ex_opcode;
                wb_dest   <= ex_dest;
                wb_data   <= ex_result;
                wb_carry  <= ex_carry;
            end
            if (wb_valid) begin
                retired_count <= retired_count + 1'b1;
            end
            if (commit_write) begin
                flag_zero  <= (wb_data == '0);
                flag_carry <= wb_carry;
            end
            if (commit_halt) begin
                halted <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_data_a = rf_data_a;
        rd_data_b = rf_data_b;
`ifdef RISC_WB_FORWARD_EN
        if (commit_write && (wb_dest == rd_addr_a)) rd_data_a = wb_data;
        if (commit_write && (wb_dest == rd_addr_b)) rd_data_b = wb_data;
`endif
    end

endmodule

// File: tb/tb_risc_writeback_stage.sv
// Directed plus randomized bench for risc_writeback_stage against an instruction-level model.
module tb_risc_writeback_stage;
    import risc_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              ex_valid;
    logic [3:0]        ex_opcode;
    logic [IDX_W-1:0]  ex_dest;
    logic [DATA_W-1:0] ex_result;
    logic              ex_carry;
    logic [IDX_W-1:0]  rd_addr_a;
    logic [IDX_W-1:0]  rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              wb_valid;
    logic [IDX_W-1:0]  wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic              flag_zero;
    logic              flag_carry;
    logic              halted;
    logic [CNT_W-1:0]  retired_count;

    always #5 clk = ~clk;

    risc_writeback_stage dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_opcode     (ex_opcode),
        .ex_dest       (ex_dest),
        .ex_result     (ex_result),
        .ex_carry      (ex_carry),
        .rd_addr_a     (rd_addr_a),
        .rd_addr_b     (rd_addr_b),
        .rd_data_a     (rd_data_a),
        .rd_data_b     (rd_data_b),
        .wb_valid      (wb_valid),
        .wb_dest       (wb_dest),
        .wb_data       (wb_data),
        .flag_zero     (flag_zero),
        .flag_carry    (flag_carry),
        .halted        (halted),
        .retired_count (retired_count)
    );

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] dest;
        logic [7:0] res;
        logic       carry;
    } instr_t;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: architectural state plus the list of instructions still in flight.
    logic [7:0]  m_rf [4];
    logic        m_z, m_c, m_h;
    logic [15:0] m_cnt;
    instr_t      exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rf[0] = 8'd5; m_rf[1] = 8'd10; m_rf[2] = 8'd15; m_rf[3] = 8'd20;
        m_z = 1'b0; m_c = 1'b0; m_h = 1'b0; m_cnt = 16'd0;
        exp_q.delete();
    endtask

    // One clock edge: the oldest in-flight instruction retires, then the new one is accepted.
    task automatic model_edge(input instr_t t, input logic v);
        instr_t old;
        if (exp_q.size() > 0) begin
            old = exp_q.pop_front();
            m_cnt = m_cnt + 16'd1;
            if (old.op == 4'hF) m_h = 1'b1;
            else if (old.op != 4'h0) begin
                m_rf[old.dest] = old.res;
                m_z = (old.res == 8'h00);
                m_c = old.carry;
            end
        end
        if (v && !m_h) exp_q.push_back(t);
    endtask

    function automatic logic [7:0] model_read(input logic [1:0] addr);
`ifdef RISC_WB_FORWARD_EN
        if (exp_q.size() > 0 && exp_q[0].op != 4'h0 && exp_q[0].op != 4'hF && exp_q[0].dest == addr)
            return exp_q[0].res;
`endif
        return m_rf[addr];
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            chk({tag, ".wb_dest"}, 32'(wb_dest), 32'(exp_q[0].dest));
            chk({tag, ".wb_data"}, 32'(wb_data), 32'(exp_q[0].res));
        end
        chk({tag, ".flag_zero"}, 32'(flag_zero), 32'(m_z));
        chk({tag, ".flag_carry"}, 32'(flag_carry), 32'(m_c));
        chk({tag, ".halted"}, 32'(halted), 32'(m_h));
        chk({tag, ".retired"}, 32'(retired_count), 32'(m_cnt));
        for (int i = 0; i < 4; i++) begin
            rd_addr_a = 2'(i);
            rd_addr_b = 2'($urandom_range(0, 3));
            #1;
            chk({tag, ".rd_a"}, 32'(rd_data_a), 32'(model_read(rd_addr_a)));
            chk({tag, ".rd_b"}, 32'(rd_data_b), 32'(model_read(rd_addr_b)));
        end
    endtask

    task automatic drive_edge(input logic v, input logic [3:0] op, input logic [1:0] dest,
                              input logic [7:0] res, input logic carry);
        instr_t t;
        t = '{op: op, dest: dest, res: res, carry: carry};
        ex_valid = v; ex_opcode = op; ex_dest = dest; ex_result = res; ex_carry = carry;
        @(posedge clk);
        model_edge(t, v);
        #1;
    endtask

    task automatic step(input string tag, input logic v, input logic [3:0] op,
                        input logic [1:0] dest, input logic [7:0] res, input logic carry);
        drive_edge(v, op, dest, res, carry);
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; ex_valid = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
        check_state(tag);
    endtask

    initial begin
        reset = 1'b1;
        ex_valid = 1'b0; ex_opcode = 4'h0; ex_dest = '0; ex_result = '0; ex_carry = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0;
        model_reset();
        @(posedge clk);

        // Reset state, with the reset values written out as constants.
        do_reset("reset");
        chk("reset.wb_dest", 32'(wb_dest), 32'd0);
        chk("reset.wb_data", 32'(wb_data), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd_addr_a = 2'(i); rd_addr_b = 2'(3 - i);
            #1;
            chk("reset.rd_a_const", 32'(rd_data_a), 32'(5 * (i + 1)));
            chk("reset.rd_b_const", 32'(rd_data_b), 32'(5 * (4 - i)));
        end

        // Basic write with carry: visible in WB after edge N, committed after N+1.
        step("w_r2", 1'b1, 4'h1, 2'd2, 8'h2A, 1'b1);
        chk("w_r2.wb_data_const", 32'(wb_data), 32'h2A);
        step("w_r2_commit", 1'b0, 4'h0, 2'd0, 8'h00, 1'b0);
        chk("w_r2.count_const", 32'(retired_count), 32'd1);
        chk("w_r2.carry_const", 32'(flag_carry), 32'd1);

        // Zero result, then NOP leaves registers and flags alone.
        step("zero", 1'b1, 4'h3, 2'd1, 8'h00, 1'b0);
        step("nop", 1'b1, 4'h0, 2'd1, 8'hFF, 1'b1);
        chk("zero.flag_const", 32'(flag_zero), 32'd1);
        step("nop_commit", 1'b0, 4'h0, 2'd0, 8'h00, 1'b0);

        // Read of a register pending in WB, then the next cycle.
        drive_edge(1'b1, 4'h2, 2'd3, 8'h77, 1'b0);
        ex_valid = 1'b0;
        rd_addr_a = 2'd3;
        #1;
`ifdef RISC_WB_FORWARD_EN
        chk("fwd.rd_a_pending", 32'(rd_data_a), 32'h77);
`else
        chk("fwd.rd_a_pending", 32'(rd_data_a), 32'd20);
`endif
        step("fwd_commit", 1'b0, 4'h0, 2'd0, 8'h00, 1'b0);
        rd_addr_a = 2'd3;
        #1;
        chk("fwd.rd_a_after", 32'(rd_data_a), 32'h77);

        // Back-to-back writes to the same register; the later one wins.
        step("b2b_1", 1'b1, 4'h4, 2'd0, 8'h11, 1'b0);
        step("b2b_2", 1'b1, 4'h5, 2'd0, 8'h22, 1'b1);
        step("b2b_done", 1'b0, 4'h0, 2'd0, 8'h00, 1'b0);

        // Randomized traffic without HALT.
        for (int i = 0; i < 200; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 14)),
                 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        step("rand_drain", 1'b0, 4'h0, 2'd0, 8'h00, 1'b0);

        // Reset while a write sits in WB discards it.
        step("mid_write", 1'b1, 4'h6, 2'd0, 8'h99, 1'b1);
        do_reset("mid_reset");
        chk("mid_reset.r0", 32'(m_rf[0] == 8'd5), 32'd1);

        // HALT followed by writing ops.
        step("pre_halt", 1'b1, 4'h7, 2'd1, 8'h44, 1'b0);
        step("halt", 1'b1, 4'hF, 2'd2, 8'h55, 1'b1);
        step("post1", 1'b1, 4'h8, 2'd2, 8'h66, 1'b1);
        chk("halt.halted_const", 32'(halted), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step("post_halt", 1'b1, 4'($urandom_range(1, 14)), 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        chk("halt.count_const", 32'(retired_count), 32'd2);

        // Counter wrap through 65535 NOPs and one more.
        do_reset("wrap_reset");
        for (int i = 0; i < 65535; i++) begin
            drive_edge(1'b1, 4'h0, 2'd0, 8'h00, 1'b0);
        end
        step("wrap_ffff", 1'b0, 4'h0, 2'd0, 8'h00, 1'b0);
        chk("wrap.ffff_const", 32'(retired_count), 32'hFFFF);
        step("wrap_nop", 1'b1, 4'h0, 2'd0, 8'h00, 1'b0);
        step("wrap_zero", 1'b0, 4'h0, 2'd0, 8'h00, 1'b0);
        chk("wrap.zero_const", 32'(retired_count), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
